// File: rtl/piso_reader_if.sv
// Handshake bundle for piso_reader: a parallel load port and a serial bit port.
// The reader connects through the slave modport and its environment through the master modport.
interface piso_reader_if #(
  parameter int S = 2
);
  localparam int W = 1 << S;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_bit;
  logic         out_last;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_bit,
    input  out_last
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_bit,
    output out_last
  );
endinterface

// File: rtl/piso_reader.sv
// Parallel-in/serial-out reader: loads a 2**S-bit word and shifts it out one bit per transfer,
// with a last-bit marker and no bubble between back-to-back words.
module piso_reader #(
  parameter int S         = 2,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  piso_reader_if.slave   bus,
  output logic           fsm_state
);
  localparam int W = 1 << S;
  localparam logic [S-1:0] CNT_LAST = {S{1'b1}};

  // Handshakes: a load is accepted when in_valid & in_ready at a rising edge; a bit is
  // transferred when out_valid & out_ready at a rising edge. Neither side may retract valid.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [W-1:0] sr;
  logic [W-1:0] sr_nxt;
  logic [S-1:0] cnt;
  logic [S-1:0] cnt_nxt;
  logic         out_valid_q;
  logic         out_bit_q;
  logic         out_last_q;
  logic         load_acc;
  logic         xfer;

  // The only combinational input-to-output path: out_ready lets a new word in on the last bit.
  assign bus.in_ready = (state == IDLE) | ((state == SHIFT) & out_last_q & bus.out_ready);
  assign load_acc     = bus.in_valid & bus.in_ready;
  assign xfer         = out_valid_q & bus.out_ready;

  assign bus.out_valid = out_valid_q;
  assign bus.out_bit   = out_bit_q;
  assign bus.out_last  = out_last_q;
  assign fsm_state     = (state == SHIFT);

  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (load_acc) begin
          sr_nxt    = bus.in_data;
          cnt_nxt   = '0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (xfer) begin
          if (!out_last_q) begin
            sr_nxt  = MSB_FIRST ? (sr << 1) : (sr >> 1);
            cnt_nxt = cnt + 1'b1;
          end else if (load_acc) begin
            sr_nxt  = bus.in_data;
            cnt_nxt = '0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so out_bit never depends on in_data
  // combinationally and holds steady under backpressure.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      sr          <= '0;
      cnt         <= '0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state       <= state_nxt;
      sr          <= sr_nxt;
      cnt         <= cnt_nxt;
      out_valid_q <= (state_nxt == SHIFT);
      out_bit_q   <= (state_nxt == SHIFT) & (MSB_FIRST ? sr_nxt[W-1] : sr_nxt[0]);
      out_last_q  <= (state_nxt == SHIFT) & (cnt_nxt == CNT_LAST);
    end
  end
endmodule
